mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares one memory port between the CPU instruction-fetch port (instr_*) and data port (data_*). It sits between the CPU core and the single-ported program/data memory. It grants one strobe/acknowledge transaction at a time using round-robin priority, and forwards the memory acknowledge and read data to the granted requester only.

---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one strobe/ack memory port between the CPU instruction and data ports.
// Define MEM_ARB_TIMEOUT_EN to abort a grant that sees no mem_ack_i within TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              instr_stb_i,
    input  logic              instr_we_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    input  logic [DATA_W-1:0] instr_data_i,
    output logic [DATA_W-1:0] instr_data_o,
    output logic              instr_ack_o,
    input  logic              data_stb_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_data_i,
    output logic [DATA_W-1:0] data_data_o,
    output logic              data_ack_o,
    output logic              mem_stb_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [1:0]        grant_o,
    output logic              arb_err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state;
    logic   last_gnt_d;
    logic   sel_i;
    logic   sel_d;
    logic   cur_stb;
    logic   timeout_hit;

    assign sel_i   = (state == GNT_I);
    assign sel_d   = (state == GNT_D);
    assign cur_stb = (sel_i & instr_stb_i) | (sel_d & data_stb_i);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    // The cycle that would bring the stall count to TIMEOUT is the abort cycle itself.
    assign timeout_hit = cur_stb & ~mem_ack_i & (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else if (!mem_ack_i) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    // TIMEOUT has no effect when stalled grants are never aborted.
    localparam int unused_timeout = TIMEOUT;

    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        mem_stb_o  = cur_stb & ~timeout_hit;
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        if (sel_i) begin
            mem_we_o   = instr_we_i;
            mem_addr_o = instr_addr_i;
            mem_data_o = instr_data_i;
        end else if (sel_d) begin
            mem_we_o   = data_we_i;
            mem_addr_o = data_addr_i;
            mem_data_o = data_data_i;
        end
    end

    // An aborted transaction is still acknowledged so the requester can release its strobe.
    assign instr_ack_o  = sel_i & (mem_ack_i | timeout_hit);
    assign data_ack_o   = sel_d & (mem_ack_i | timeout_hit);
    assign instr_data_o = sel_i ? mem_data_i : '0;
    assign data_data_o  = sel_d ? mem_data_i : '0;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state      <= IDLE;
            last_gnt_d <= 1'b1;
            grant_o    <= 2'b00;
            arb_err_o  <= 1'b0;
        end else begin
            arb_err_o <= timeout_hit;
            unique case (state)
                IDLE: begin
                    // On a collision the side that did not win last time goes first.
                    if (instr_stb_i && (!data_stb_i || last_gnt_d)) begin
                        state      <= GNT_I;
                        last_gnt_d <= 1'b0;
                        grant_o    <= 2'b01;
                    end else if (data_stb_i) begin
                        state      <= GNT_D;
                        last_gnt_d <= 1'b1;
                        grant_o    <= 2'b10;
                    end
                end
                GNT_I, GNT_D: begin
                    if (mem_ack_i || !cur_stb || timeout_hit) begin
                        state   <= IDLE;
                        grant_o <= 2'b00;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic          instr_stb_i = 1'b0, instr_we_i = 1'b0;
    logic [AW-1:0] instr_addr_i = '0;
    logic [DW-1:0] instr_data_i = '0;
    logic [DW-1:0] instr_data_o;
    logic          instr_ack_o;
    logic          data_stb_i = 1'b0, data_we_i = 1'b0;
    logic [AW-1:0] data_addr_i = '0;
    logic [DW-1:0] data_data_i = '0;
    logic [DW-1:0] data_data_o;
    logic          data_ack_o;
    logic          mem_stb_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [DW-1:0] mem_data_i = '0;
    logic          mem_ack_i = 1'b0;
    logic [1:0]    grant_o;
    logic          arb_err_o;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .instr_stb_i(instr_stb_i), .instr_we_i(instr_we_i), .instr_addr_i(instr_addr_i),
        .instr_data_i(instr_data_i), .instr_data_o(instr_data_o), .instr_ack_o(instr_ack_o),
        .data_stb_i(data_stb_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_data_i(data_data_i), .data_data_o(data_data_o), .data_ack_o(data_ack_o),
        .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .grant_o(grant_o), .arb_err_o(arb_err_o)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Model: who owns the port (0 none, 1 instr, 2 data), who won last, stall cycles so far.
    int owner;
    bit last_was_data;
    bit exp_err;
    int stall;
    bit abort_now;
    bit exp_ack_i, exp_ack_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = 0; last_was_data = 1'b1; exp_err = 1'b0; stall = 0;
        abort_now = 1'b0; exp_ack_i = 1'b0; exp_ack_d = 1'b0;
    endtask

    function automatic logic owner_stb();
        if (owner == 1) return instr_stb_i;
        if (owner == 2) return data_stb_i;
        return 1'b0;
    endfunction

    // Settle mid-cycle and compare every output with the model.
    task automatic check_cycle();
        logic stb;
        #3;
        stb = owner_stb();
        abort_now = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        abort_now = (owner != 0) && stb && !mem_ack_i && (stall == TO - 1);
`endif
        exp_ack_i = (owner == 1) && (mem_ack_i || abort_now);
        exp_ack_d = (owner == 2) && (mem_ack_i || abort_now);
        chk("mem_stb", mem_stb_o, stb && !abort_now);
        chk("mem_we", mem_we_o, owner == 1 ? instr_we_i : owner == 2 ? data_we_i : 1'b0);
        chk("mem_addr", mem_addr_o, owner == 1 ? instr_addr_i : owner == 2 ? data_addr_i : '0);
        chk("mem_data", mem_data_o, owner == 1 ? instr_data_i : owner == 2 ? data_data_i : '0);
        chk("instr_ack", instr_ack_o, exp_ack_i);
        chk("data_ack", data_ack_o, exp_ack_d);
        chk("instr_rdata", instr_data_o, owner == 1 ? mem_data_i : '0);
        chk("data_rdata", data_data_o, owner == 2 ? mem_data_i : '0);
        chk("grant", grant_o, owner == 1 ? 2'b01 : owner == 2 ? 2'b10 : 2'b00);
        chk("arb_err", arb_err_o, exp_err);
    endtask

    // Apply the arbitration rules for this cycle's inputs, then move to the next cycle.
    task automatic advance();
        exp_err = abort_now;
        if (owner == 0) begin
            if (instr_stb_i && data_stb_i) owner = last_was_data ? 1 : 2;
            else if (instr_stb_i) owner = 1;
            else if (data_stb_i) owner = 2;
            if (owner != 0) begin
                last_was_data = (owner == 2);
                stall = 0;
            end
        end else if (mem_ack_i || !owner_stb() || abort_now) begin
            owner = 0;
        end else begin
            stall++;
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b0;
        #1;
        chk("rst_mem_stb", mem_stb_o, 1'b0);
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_err", arb_err_o, 1'b0);
        chk("rst_acks", {instr_ack_o, data_ack_o}, 2'b00);
        model_reset();
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
    endtask

    initial begin
        logic [1:0] seq [8];
        int pulses;
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b00; seq[3] = 2'b10;
        seq[4] = 2'b00; seq[5] = 2'b01; seq[6] = 2'b00; seq[7] = 2'b10;
        model_reset();
        do_reset();

        // Single instruction read, acked on the first granted cycle.
        instr_stb_i = 1'b1; instr_addr_i = 16'h0010;
        check_cycle(); advance();
        mem_ack_i = 1'b1; mem_data_i = 16'h1234;
        check_cycle();
        chk("t1_stb", mem_stb_o, 1'b1);
        chk("t1_addr", mem_addr_o, 16'h0010);
        chk("t1_ack", instr_ack_o, 1'b1);
        chk("t1_rdata", instr_data_o, 16'h1234);
        chk("t1_dack", data_ack_o, 1'b0);
        advance();
        instr_stb_i = 1'b0; mem_ack_i = 1'b0;
        check_cycle(); advance();

        // Collision from reset: I, D, I, D with an idle cycle between grants.
        do_reset();
        instr_stb_i = 1'b1; data_stb_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_ack_i = (grant_o != 2'b00);
            check_cycle();
            chk("gnt_seq", grant_o, seq[i]);
            advance();
        end
        instr_stb_i = 1'b0; data_stb_i = 1'b0; mem_ack_i = 1'b0;
        check_cycle(); advance();

        // Data write with ack on the third granted cycle.
        data_stb_i = 1'b1; data_we_i = 1'b1; data_addr_i = 16'h0005; data_data_i = 16'hBEEF;
        check_cycle(); advance();
        pulses = 0;
        for (int k = 1; k <= 3; k++) begin
            mem_ack_i = (k == 3);
            check_cycle();
            chk("t3_we", mem_we_o, 1'b1);
            chk("t3_wdata", mem_data_o, 16'hBEEF);
            chk("t3_dack", data_ack_o, k == 3);
            pulses += int'(data_ack_o);
            advance();
        end
        data_stb_i = 1'b0; data_we_i = 1'b0; mem_ack_i = 1'b0;
        check_cycle();
        chk("t3_pulses", pulses, 1);
        advance();

        // Instruction request abandoned after one granted cycle.
        instr_stb_i = 1'b1; instr_addr_i = 16'h0100;
        check_cycle(); advance();
        check_cycle();
        chk("t4_stb_up", mem_stb_o, 1'b1);
        advance();
        instr_stb_i = 1'b0;
        check_cycle();
        chk("t4_stb_drop", mem_stb_o, 1'b0);
        chk("t4_no_ack", instr_ack_o, 1'b0);
        advance();
        check_cycle();
        chk("t4_idle", grant_o, 2'b00);
        advance();

        // Asynchronous reset in the middle of a data grant.
        data_stb_i = 1'b1; data_addr_i = 16'h0042;
        check_cycle(); advance();
        mem_ack_i = 1'b1; mem_data_i = 16'hABCD;
        #1 sys_rst = 1'b0;
        #1;
        chk("t5_stb", mem_stb_o, 1'b0);
        chk("t5_addr", mem_addr_o, 16'h0000);
        chk("t5_grant", grant_o, 2'b00);
        chk("t5_dack", data_ack_o, 1'b0);
        chk("t5_rdata", data_data_o, 16'h0000);
        mem_ack_i = 1'b0;
        model_reset();
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        check_cycle(); advance();
        check_cycle();
        chk("t5_regrant", grant_o, 2'b10);
        mem_ack_i = 1'b1;
        advance();
        data_stb_i = 1'b0; mem_ack_i = 1'b0;
        check_cycle(); advance();

        // Stalled memory: abort on the TIMEOUT-th granted cycle, or wait indefinitely.
        instr_stb_i = 1'b1; instr_addr_i = 16'h0200;
        check_cycle(); advance();
`ifdef MEM_ARB_TIMEOUT_EN
        for (int k = 1; k <= TO; k++) begin
            check_cycle();
            chk("t6_to_ack", instr_ack_o, k == TO);
            advance();
        end
        instr_stb_i = 1'b0;
        check_cycle();
        chk("t6_err", arb_err_o, 1'b1);
        advance();
        check_cycle();
        chk("t6_err_once", arb_err_o, 1'b0);
        advance();
`else
        for (int k = 0; k < 100; k++) begin
            check_cycle(); advance();
        end
        check_cycle();
        chk("t6_still_stb", mem_stb_o, 1'b1);
        chk("t6_still_gnt", grant_o, 2'b01);
        chk("t6_no_err", arb_err_o, 1'b0);
        mem_ack_i = 1'b1;
        advance();
        instr_stb_i = 1'b0; mem_ack_i = 1'b0;
        check_cycle(); advance();
`endif

        // Randomized traffic: requests held until acked, occasionally abandoned.
        for (int n = 0; n < 400; n++) begin
            if (exp_ack_i) instr_stb_i = 1'b0;
            else if (instr_stb_i) instr_stb_i = ($urandom_range(0, 19) != 0);
            else instr_stb_i = ($urandom_range(0, 2) == 0);
            if (exp_ack_d) data_stb_i = 1'b0;
            else if (data_stb_i) data_stb_i = ($urandom_range(0, 19) != 0);
            else data_stb_i = ($urandom_range(0, 2) == 0);
            instr_we_i   = 1'($urandom);
            data_we_i    = 1'($urandom);
            instr_addr_i = 16'($urandom);
            data_addr_i  = 16'($urandom);
            instr_data_i = 16'($urandom);
            data_data_i  = 16'($urandom);
            mem_data_i   = 16'($urandom);
            mem_ack_i    = ($urandom_range(0, 3) == 0);
            check_cycle();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
